// File: rtl/led_overlay_pkg.sv
// Shared types and constants for the LED palette overlay scheduler.
// Holds the FSM state encoding, the 24-bit RGB record and the hold-counter width.
package led_overlay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } t_overlay_state;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } t_rgb24;

  localparam int c_tick_width = 8;

  // Index width for a population of n items, never narrower than one bit.
  function automatic int f_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// Free-running clock-enable generator: one-cycle o_ce pulse every
// parm_divisor cycles in which i_ce_mhz is high. Output is registered.
module clock_enable_divider #(
  parameter int parm_divisor = 2
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_ce_mhz,
  output logic o_ce
);

  localparam int c_cnt_width = (parm_divisor > 1) ? $clog2(parm_divisor) : 1;
  localparam logic [c_cnt_width-1:0] c_last = c_cnt_width'(parm_divisor - 1);

  logic [c_cnt_width-1:0] cnt_q;
  logic                   ce_q;

  // Count enabled cycles and emit a registered pulse on wrap.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      ce_q <= 1'b0;
      if (i_ce_mhz) begin
        if (cnt_q == c_last) begin
          cnt_q <= '0;
          ce_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + c_cnt_width'(1);
        end
      end
    end
  end

  assign o_ce = ce_q;

endmodule

// File: rtl/led_overlay_arbiter.sv
// Combinational winner select for the shared overlay slot.
// Build option: LED_OVERLAY_ROUND_ROBIN_EN selects round-robin search from a
// rotating pointer; otherwise fixed priority (lowest index wins) with no state.
module led_overlay_arbiter
  import led_overlay_pkg::*;
#(
  parameter int parm_requester_count = 2,
  parameter int c_win_width          = f_clog2_min1(parm_requester_count)
) (
  input  logic                            i_clk,
  input  logic                            i_srst,
  input  logic [parm_requester_count-1:0] i_req,
  input  logic                            i_advance,
  output logic [c_win_width-1:0]          o_winner,
  output logic                            o_valid
);

`ifdef LED_OVERLAY_ROUND_ROBIN_EN

  logic [c_win_width-1:0] ptr_q;
  int                     cand_s;

  // Search requesters starting at the pointer, wrapping around once.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    cand_s   = 0;
    for (int k = 0; k < parm_requester_count; k++) begin
      cand_s = (int'(ptr_q) + k) % parm_requester_count;
      if (!o_valid && i_req[cand_s]) begin
        o_winner = c_win_width'(cand_s);
        o_valid  = 1'b1;
      end else begin
        o_valid  = o_valid;
      end
    end
  end

  // Move the pointer past the winner each time a grant is taken.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      ptr_q <= '0;
    end else if (i_advance && o_valid) begin
      if (int'(o_winner) == parm_requester_count - 1) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= o_winner + c_win_width'(1);
      end
    end
  end

`else

  logic unused_s;
  assign unused_s = ^{i_clk, i_srst, i_advance};

  // Scan from the top down so the lowest asserted index is the last written.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int i = parm_requester_count - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_winner = c_win_width'(i);
        o_valid  = 1'b1;
      end else begin
        o_valid  = o_valid;
      end
    end
  end

`endif

endmodule

// File: rtl/led_palette_overlay_scheduler.sv
// Palette pass-through with one shared, timed single-LED colour overlay slot.
// Build option: LED_OVERLAY_ROUND_ROBIN_EN (round-robin arbitration among
// requesters; default is fixed priority, lowest index wins).
module led_palette_overlay_scheduler
  import led_overlay_pkg::*;
#(
  parameter int parm_color_led_count  = 4,
  parameter int parm_requester_count  = 2,
  parameter int parm_FCLK             = 40_000_000,
  parameter int parm_ticks_per_second = 128,
  parameter int c_idx_width           = $clog2(parm_color_led_count)
) (
  input  logic                                         i_clk,
  input  logic                                         i_srst,
  input  logic [8*parm_color_led_count-1:0]            i_base_red_value,
  input  logic [8*parm_color_led_count-1:0]            i_base_green_value,
  input  logic [8*parm_color_led_count-1:0]            i_base_blue_value,
  input  logic [parm_requester_count-1:0]              i_req,
  input  logic [c_idx_width*parm_requester_count-1:0]  i_req_led_idx,
  input  logic [24*parm_requester_count-1:0]           i_req_rgb,
  input  logic [c_tick_width*parm_requester_count-1:0] i_req_ticks,
  output logic [parm_requester_count-1:0]              o_gnt,
  output logic [parm_requester_count-1:0]              o_done,
  output logic                                         o_busy,
  output logic [8*parm_color_led_count-1:0]            o_color_led_red_value,
  output logic [8*parm_color_led_count-1:0]            o_color_led_green_value,
  output logic [8*parm_color_led_count-1:0]            o_color_led_blue_value
);

  localparam int c_count     = parm_color_led_count;
  localparam int c_req       = parm_requester_count;
  localparam int c_win_width = f_clog2_min1(c_req);
  localparam int c_divisor   = parm_FCLK / parm_ticks_per_second;

  logic                    tick_s;
  logic [c_win_width-1:0]  winner_s;
  logic                    valid_s;

  logic [c_idx_width-1:0]  win_idx_s;
  t_rgb24                  win_rgb_s;
  logic [c_tick_width-1:0] win_ticks_s;
  logic [c_req-1:0]        win_onehot_s;
  logic [c_req-1:0]        owner_onehot_s;

  logic                    hold_next_s;
  logic [c_idx_width-1:0]  ovl_idx_next_s;
  t_rgb24                  ovl_rgb_next_s;

  t_overlay_state          state_q;
  logic [c_idx_width-1:0]  idx_q;
  t_rgb24                  rgb_q;
  logic [c_tick_width-1:0] cnt_q;
  logic [c_win_width-1:0]  owner_q;
  logic [c_req-1:0]        gnt_q;
  logic [c_req-1:0]        done_q;
  logic                    busy_q;

  logic [8*c_count-1:0]    red_d,   red_q;
  logic [8*c_count-1:0]    green_d, green_q;
  logic [8*c_count-1:0]    blue_d,  blue_q;

  clock_enable_divider #(
    .parm_divisor (c_divisor)
  ) u_tick (
    .i_clk    (i_clk),
    .i_srst   (i_srst),
    .i_ce_mhz (1'b1),
    .o_ce     (tick_s)
  );

  led_overlay_arbiter #(
    .parm_requester_count (c_req),
    .c_win_width          (c_win_width)
  ) u_arb (
    .i_clk     (i_clk),
    .i_srst    (i_srst),
    .i_req     (i_req),
    .i_advance (state_q == ST_IDLE),
    .o_winner  (winner_s),
    .o_valid   (valid_s)
  );

  // Pick out the winning requester's fields and build one-hot vectors.
  always_comb begin
    win_idx_s      = '0;
    win_rgb_s      = '0;
    win_ticks_s    = '0;
    win_onehot_s   = '0;
    owner_onehot_s = '0;
    for (int r = 0; r < c_req; r++) begin
      if (int'(winner_s) == r) begin
        win_idx_s       = i_req_led_idx[r*c_idx_width +: c_idx_width];
        win_rgb_s       = i_req_rgb[r*24 +: 24];
        win_ticks_s     = i_req_ticks[r*c_tick_width +: c_tick_width];
        win_onehot_s[r] = 1'b1;
      end else begin
        win_onehot_s[r] = 1'b0;
      end
      if (int'(owner_q) == r) begin
        owner_onehot_s[r] = 1'b1;
      end else begin
        owner_onehot_s[r] = 1'b0;
      end
    end
  end

  // Predict whether the slot is in HOLD next cycle so the registered palette
  // shows the overlay exactly while the FSM sits in ST_HOLD.
  always_comb begin
    hold_next_s    = 1'b0;
    ovl_idx_next_s = idx_q;
    ovl_rgb_next_s = rgb_q;
    case (state_q)
      ST_IDLE: begin
        hold_next_s    = valid_s;
        ovl_idx_next_s = win_idx_s;
        ovl_rgb_next_s = win_rgb_s;
      end
      ST_HOLD: begin
        hold_next_s = !(tick_s && (cnt_q <= c_tick_width'(1)));
      end
      default: begin
        hold_next_s = 1'b0;
      end
    endcase
  end

  // Baseline palette with the latched LED's bytes replaced during hold.
  // An out-of-range index matches no LED, so nothing is overridden.
  always_comb begin
    red_d   = i_base_red_value;
    green_d = i_base_green_value;
    blue_d  = i_base_blue_value;
    for (int n = 0; n < c_count; n++) begin
      if (hold_next_s && (int'(ovl_idx_next_s) == n)) begin
        red_d[8*n +: 8]   = ovl_rgb_next_s.red;
        green_d[8*n +: 8] = ovl_rgb_next_s.green;
        blue_d[8*n +: 8]  = ovl_rgb_next_s.blue;
      end else begin
        red_d[8*n +: 8]   = i_base_red_value[8*n +: 8];
      end
    end
  end

  // Register the palette outputs.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  // Overlay slot FSM with registered grant, done and busy outputs.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rgb_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (valid_s) begin
            state_q <= ST_HOLD;
            idx_q   <= win_idx_s;
            rgb_q   <= win_rgb_s;
            cnt_q   <= win_ticks_s;
            owner_q <= winner_s;
            gnt_q   <= win_onehot_s;
            busy_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          busy_q <= 1'b1;
          if (tick_s) begin
            if (cnt_q <= c_tick_width'(1)) begin
              state_q <= ST_RELEASE;
              done_q  <= owner_onehot_s;
            end else begin
              cnt_q <= cnt_q - c_tick_width'(1);
            end
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt                   = gnt_q;
  assign o_done                  = done_q;
  assign o_busy                  = busy_q;
  assign o_color_led_red_value   = red_q;
  assign o_color_led_green_value = green_q;
  assign o_color_led_blue_value  = blue_q;

endmodule

// File: tb/tb_led_palette_overlay_scheduler.sv
// Self-checking bench for led_palette_overlay_scheduler (4 LEDs, 2 requesters,
// tick every 10 clocks). Honours LED_OVERLAY_ROUND_ROBIN_EN for grant order.
module tb_led_palette_overlay_scheduler;

  logic        clk;
  logic        srst;
  logic [31:0] base_r, base_g, base_b;
  logic [31:0] prev_r, prev_g, prev_b;
  logic [1:0]  req;
  logic [5:0]  req_idx;
  logic [47:0] req_rgb;
  logic [15:0] req_ticks;
  logic [1:0]  gnt, done;
  logic        busy;
  logic [31:0] out_r, out_g, out_b;

  int checks;
  int failures;
  bit rand_base;

  led_palette_overlay_scheduler #(
    .parm_color_led_count  (4),
    .parm_requester_count  (2),
    .parm_FCLK             (1280),
    .parm_ticks_per_second (128),
    .c_idx_width           (3)
  ) dut (
    .i_clk                   (clk),
    .i_srst                  (srst),
    .i_base_red_value        (base_r),
    .i_base_green_value      (base_g),
    .i_base_blue_value       (base_b),
    .i_req                   (req),
    .i_req_led_idx           (req_idx),
    .i_req_rgb               (req_rgb),
    .i_req_ticks             (req_ticks),
    .o_gnt                   (gnt),
    .o_done                  (done),
    .o_busy                  (busy),
    .o_color_led_red_value   (out_r),
    .o_color_led_green_value (out_g),
    .o_color_led_blue_value  (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: remember what the DUT captures, then optionally
  // present a fresh random baseline; returns at the next falling edge.
  task automatic cycle();
    prev_r = base_r;
    prev_g = base_g;
    prev_b = base_b;
    @(negedge clk);
    if (rand_base) begin
      base_r = $urandom;
      base_g = $urandom;
      base_b = $urandom;
    end
  endtask

  // Reference palette: previous-cycle baseline, with LED idx replaced by rgb
  // when an overlay is active and idx names a real LED (0..3).
  function automatic logic [95:0] exp_pal(input bit ovl, input int idx, input logic [23:0] rgb);
    logic [31:0] r, g, b;
    r = prev_r; g = prev_g; b = prev_b;
    for (int n = 0; n < 4; n++) begin
      if (ovl && idx == n) begin
        r[8*n +: 8] = rgb[23:16];
        g[8*n +: 8] = rgb[15:8];
        b[8*n +: 8] = rgb[7:0];
      end
    end
    return {r, g, b};
  endfunction

  task automatic test_reset();
    srst = 1'b1;
    req  = 2'b00;
    cycle();
    cycle();
    checks++;
    if ({gnt, done, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b, want all 0", gnt, done, busy);
    end
    checks++;
    if ({out_r, out_g, out_b} !== 96'h0) begin
      failures++;
      $display("FAIL reset_pal: got %h, want 0", {out_r, out_g, out_b});
    end
    srst = 1'b0;
  endtask

  task automatic test_passthrough();
    rand_base = 1'b0;
    base_r = 32'h40404040; base_g = 32'h01010101; base_b = 32'h01010101;
    cycle();
    checks++;
    if ({out_r, out_g, out_b} !== 96'h40404040_01010101_01010101 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pass_fixed: got pal=%h busy=%b, want 404040400101010101010101 busy=0",
               {out_r, out_g, out_b}, busy);
    end
    rand_base = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if ({out_r, out_g, out_b} !== exp_pal(1'b0, 0, 24'h0) || busy !== 1'b0 || gnt !== 2'b00) begin
        failures++;
        $display("FAIL pass_rand: got pal=%h busy=%b gnt=%b, want pal=%h idle",
                 {out_r, out_g, out_b}, busy, gnt, exp_pal(1'b0, 0, 24'h0));
      end
    end
  endtask

  task automatic test_single_overlay();
    int          t_idx[6];
    logic [23:0] t_rgb[6];
    int          t_ticks[6];
    t_idx[0] = 2;                    t_rgb[0] = 24'hFF0000;  t_ticks[0] = 3;
    t_idx[1] = $urandom_range(0, 3); t_rgb[1] = 24'($urandom); t_ticks[1] = $urandom_range(1, 3);
    t_idx[2] = 0;                    t_rgb[2] = 24'($urandom); t_ticks[2] = 0;
    t_idx[3] = 5;                    t_rgb[3] = 24'hABCDEF;  t_ticks[3] = 2;
    t_idx[4] = 7;                    t_rgb[4] = 24'h123456;  t_ticks[4] = 1;
    t_idx[5] = $urandom_range(0, 7); t_rgb[5] = 24'($urandom); t_ticks[5] = $urandom_range(0, 4);
    for (int c = 0; c < 6; c++) begin
      int  n, lo, hi, d;
      bit  seen;
      n  = (t_ticks[c] == 0) ? 1 : t_ticks[c];
      lo = 10 * (n - 1) + 1;
      hi = 10 * (n - 1) + 10;
      req_idx[2:0]   = 3'(t_idx[c]);
      req_rgb[23:0]  = t_rgb[c];
      req_ticks[7:0] = 8'(t_ticks[c]);
      req[0] = 1'b1;
      cycle();
      checks++;
      if (gnt !== 2'b01 || busy !== 1'b1 ||
          {out_r, out_g, out_b} !== exp_pal(1'b1, t_idx[c], t_rgb[c])) begin
        failures++;
        $display("FAIL single_gnt case %0d: got gnt=%b busy=%b pal=%h, want gnt=01 busy=1 pal=%h",
                 c, gnt, busy, {out_r, out_g, out_b}, exp_pal(1'b1, t_idx[c], t_rgb[c]));
      end
      req[0] = 1'b0;
      d = 0;
      seen = 1'b0;
      while (!seen && d <= hi) begin
        cycle();
        d++;
        if (done !== 2'b00) begin
          seen = 1'b1;
          checks++;
          if (done !== 2'b01 || d < lo || d > hi || busy !== 1'b1 ||
              {out_r, out_g, out_b} !== exp_pal(1'b0, 0, 24'h0)) begin
            failures++;
            $display("FAIL single_done case %0d: got done=%b after %0d busy=%b pal=%h, want done=01 in [%0d,%0d] busy=1 pal=%h",
                     c, done, d, busy, {out_r, out_g, out_b}, lo, hi, exp_pal(1'b0, 0, 24'h0));
          end
        end else begin
          checks++;
          if (busy !== 1'b1 || gnt !== 2'b00 ||
              {out_r, out_g, out_b} !== exp_pal(1'b1, t_idx[c], t_rgb[c])) begin
            failures++;
            $display("FAIL single_hold case %0d cyc %0d: got busy=%b gnt=%b pal=%h, want busy=1 gnt=00 pal=%h",
                     c, d, busy, gnt, {out_r, out_g, out_b}, exp_pal(1'b1, t_idx[c], t_rgb[c]));
          end
        end
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL single_timeout case %0d: got no done within %0d cycles, want done", c, hi);
      end
      cycle();
      checks++;
      if (busy !== 1'b0 || done !== 2'b00 || {out_r, out_g, out_b} !== exp_pal(1'b0, 0, 24'h0)) begin
        failures++;
        $display("FAIL single_after case %0d: got busy=%b done=%b pal=%h, want idle baseline %h",
                 c, busy, done, {out_r, out_g, out_b}, exp_pal(1'b0, 0, 24'h0));
      end
    end
  endtask

  task automatic test_arbitration();
    int          ptr, grants, owner, last_done, cyc, w;
    bit          hold;
    int          idx_of[2];
    logic [23:0] rgb_of[2];
    idx_of[0] = 1; rgb_of[0] = 24'($urandom);
    idx_of[1] = 3; rgb_of[1] = 24'($urandom);
    req_idx   = {3'(idx_of[1]), 3'(idx_of[0])};
    req_rgb   = {rgb_of[1], rgb_of[0]};
    req_ticks = {8'd1, 8'd1};
    req = 2'b11;
    ptr = 0; grants = 0; owner = 0; last_done = -100; cyc = 0; hold = 1'b0;
    while (grants < 4 && cyc < 200) begin
      cycle();
      cyc++;
      if (gnt !== 2'b00) begin
        w = 0;
`ifdef LED_OVERLAY_ROUND_ROBIN_EN
        for (int k = 1; k >= 0; k--) if (req[(ptr + k) % 2]) w = (ptr + k) % 2;
        ptr = (w + 1) % 2;
`endif
        checks++;
        if (gnt !== (2'b01 << w) || (grants > 0 && cyc - last_done != 2)) begin
          failures++;
          $display("FAIL arb_grant #%0d: got gnt=%b gap=%0d, want gnt=%b gap=2",
                   grants, gnt, cyc - last_done, 2'b01 << w);
        end
        owner = w;
        hold = 1'b1;
        grants++;
      end
      if (done !== 2'b00) begin
        checks++;
        if (done !== (2'b01 << owner) || !hold) begin
          failures++;
          $display("FAIL arb_done: got done=%b, want %b", done, 2'b01 << owner);
        end
        hold = 1'b0;
        last_done = cyc;
      end
      checks++;
      if ({out_r, out_g, out_b} !== exp_pal(hold, idx_of[owner], rgb_of[owner])) begin
        failures++;
        $display("FAIL arb_pal cyc %0d: got %h, want %h", cyc, {out_r, out_g, out_b},
                 exp_pal(hold, idx_of[owner], rgb_of[owner]));
      end
    end
    if (grants < 4) begin
      checks++;
      failures++;
      $display("FAIL arb_timeout: got %0d grants, want 4", grants);
    end
    req = 2'b00;
    for (int i = 0; i < 15; i++) cycle();
  endtask

  task automatic test_reset_mid_hold();
    int  d;
    bit  seen;
    req_idx[2:0]   = 3'd2;
    req_rgb[23:0]  = 24'h00FF00;
    req_ticks[7:0] = 8'd5;
    req[0] = 1'b1;
    cycle();
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL rst_hold_gnt: got gnt=%b, want 01", gnt);
    end
    for (int i = 0; i < 4; i++) cycle();
    srst = 1'b1;
    cycle();
    checks++;
    if ({gnt, done, busy} !== 5'b0 || {out_r, out_g, out_b} !== 96'h0) begin
      failures++;
      $display("FAIL rst_hold_zero: got gnt=%b done=%b busy=%b pal=%h, want all 0",
               gnt, done, busy, {out_r, out_g, out_b});
    end
    srst = 1'b0;
    cycle();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1 ||
        {out_r, out_g, out_b} !== exp_pal(1'b1, 2, 24'h00FF00)) begin
      failures++;
      $display("FAIL rst_regrant: got gnt=%b busy=%b pal=%h, want gnt=01 busy=1 pal=%h",
               gnt, busy, {out_r, out_g, out_b}, exp_pal(1'b1, 2, 24'h00FF00));
    end
    req[0] = 1'b0;
    d = 0;
    seen = 1'b0;
    while (!seen && d < 50) begin
      cycle();
      d++;
      if (done !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (!seen || done !== 2'b01 || d < 41) begin
      failures++;
      $display("FAIL rst_regrant_done: got done=%b after %0d, want 01 in [41,50]", done, d);
    end
    cycle();
  endtask

  task automatic test_withdrawal();
    int  d;
    bit  seen;
    req_idx   = {3'd3, 3'd1};
    req_rgb   = {24'h0000FF, 24'hFFFFFF};
    req_ticks = {8'd1, 8'd2};
    req = 2'b01;
    cycle();
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL wd_gnt0: got gnt=%b, want 01", gnt);
    end
    req = 2'b00;
    for (int i = 0; i < 3; i++) cycle();
    req = 2'b10;
    cycle();
    req = 2'b00;
    d = 0;
    seen = 1'b0;
    while (!seen && d < 30) begin
      cycle();
      d++;
      checks++;
      if (gnt !== 2'b00) begin
        failures++;
        $display("FAIL wd_no_gnt: got gnt=%b, want 00", gnt);
      end
      if (done !== 2'b00) begin
        seen = 1'b1;
        checks++;
        if (done !== 2'b01) begin
          failures++;
          $display("FAIL wd_done: got done=%b, want 01", done);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wd_timeout: got no done, want done=01");
    end
    for (int i = 0; i < 15; i++) begin
      cycle();
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL wd_idle: got gnt=%b busy=%b, want 00/0", gnt, busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rand_base = 1'b1;
    srst = 1'b1;
    req = 2'b00;
    req_idx = '0;
    req_rgb = '0;
    req_ticks = '0;
    base_r = $urandom; base_g = $urandom; base_b = $urandom;
    prev_r = base_r; prev_g = base_g; prev_b = base_b;
    test_reset();
    test_passthrough();
    test_single_overlay();
    test_arbitration();
    test_reset_mid_hold();
    test_withdrawal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/led_palette_overlay_scheduler.md
Name: led_palette_overlay_scheduler

Overview:
- Sits between the free-running palette pulser and the LED PWM driver.
- Passes the baseline palette through unchanged. Shares one timed "overlay" slot among several requesters, such as error flash and event flash.
- A granted requester forces one colour LED to a fixed 24-bit RGB for a programmed number of ticks. The baseline is then restored.

Parameters:
- parm_color_led_count, 4, number of RGB LEDs; palette buses are 8*count bits.
- parm_requester_count, 2, number of overlay requesters R.
- parm_FCLK, 40_000_000, i_clk frequency in Hz.
- parm_ticks_per_second, 128, hold-timer tick rate.
- c_idx_width, $clog2(parm_color_led_count), LED index width.

Ports:
- i_clk  in  1  system clock.
- i_srst  in  1  synchronous reset, active-high.
- i_base_red_value  in  8*count  baseline red palette; LED n is bits [8n+7:8n].
- i_base_green_value  in  8*count  baseline green palette.
- i_base_blue_value  in  8*count  baseline blue palette.
- i_req  in  R  overlay request per requester, level.
- i_req_led_idx  in  c_idx_width*R  target LED per requester.
- i_req_rgb  in  24*R  colour per requester as {red, green, blue}.
- i_req_ticks  in  8*R  hold duration in ticks.
- o_gnt  out  R  one-cycle grant pulse.
- o_done  out  R  one-cycle completion pulse.
- o_busy  out  1  overlay slot occupied.
- o_color_led_red_value  out  8*count  palette to PWM driver.
- o_color_led_green_value  out  8*count.
- o_color_led_blue_value  out  8*count.

Behaviour:
- Tick: a clock_enable_divider instance with divisor parm_FCLK/parm_ticks_per_second, i_ce_mhz tied to 1. The tick is free-running and is not restarted on grant.
- Reset: all outputs 0; state ST_IDLE; latched index, RGB and counter cleared; round-robin pointer 0.
- Palette outputs are registered with 1-cycle latency from the base inputs. In ST_HOLD, the three bytes of the latched LED index are replaced by the latched RGB. All other LEDs always follow the baseline.
- FSM:
  - ST_IDLE: o_busy=0. If any i_req bit is set, the arbiter picks a winner. Latch its index, RGB and ticks. Pulse o_gnt[winner] in the next cycle, together with entry to ST_HOLD.
  - ST_HOLD: o_busy=1. On each tick: if counter <= 1, go to ST_RELEASE; otherwise decrement. Hold time is N-1 to N tick periods for N >= 1. Ticks 0 behaves as ticks 1.
  - ST_RELEASE: lasts one cycle. Baseline output for the latched LED. Pulse o_done[owner]. o_busy=1. Next state is ST_IDLE.
- Re-arbitration is possible only in ST_IDLE, so back-to-back grants are separated by at least one idle cycle.
- Requests:
  - A requester holds i_req until it sees o_gnt. Dropping i_req before grant withdraws the request.
  - i_req is ignored while busy. A requester still asserting i_req after o_done is granted again.
- Out-of-range LED index (>= count): the request is still granted, timed and completed, but no LED is overridden.
- Arbitration (default): fixed priority, lowest index wins.
- Simultaneous events: a request rising in the same cycle as ST_RELEASE is seen in the following ST_IDLE cycle.
- Reset mid-hold: overlay aborted immediately, no o_done, outputs 0 on the next cycle.
- Baseline changes during hold are reflected on non-overlaid LEDs with 1-cycle latency.

Optional Feature:
- Macro: LED_OVERLAY_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The pointer moves to (winner+1) mod R on each grant, and the search starts at the pointer.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.

Decomposition:
- Package led_overlay_pkg holds:
  - enum t_overlay_state {ST_IDLE, ST_HOLD, ST_RELEASE}, 2 bits;
  - packed struct t_rgb24 {red, green, blue} of 8 bits each;
  - constant c_tick_width = 8.
- Sub-module led_overlay_arbiter: combinational winner select with valid output, plus the optional round-robin pointer register.
- Existing clock_enable_divider is reused.

Test Plan (parm_FCLK=1280, parm_ticks_per_second=128, giving a tick every 10 clocks; R=2, count=4):
- Base red=0x40404040, green/blue=0x01010101, no req -> outputs equal inputs 1 cycle later; o_busy=0.
- Single request: req[0], idx=2, rgb=0xFF0000, ticks=3 -> o_gnt[0] one cycle; LED2 = FF/00/00 for 20-30 clocks; o_done[0]; LED2 back to 0x40/01/01.
- Arbitration: req[0] and req[1] together, both held.
  - Fixed priority: grant order 0, 0, 0…
  - With LED_OVERLAY_ROUND_ROBIN_EN: grant order 0, 1, 0, 1.
- Edge cases:
  - ticks=0 -> released at the first tick, within 10 clocks.
  - idx=5 with count=4 -> gnt/done pulse, palette unchanged throughout.
- Reset mid-hold: assert i_srst for 1 cycle during ST_HOLD -> next cycle all outputs 0, no o_done; the held req is re-granted after reset.
- Withdrawal: req[1] pulsed 1 cycle while busy with req[0] -> never granted; o_done[0] only.
